// File: rtl/arb_pkg.sv
// Shared arbitration helpers: round-robin pick function and the double-buffer
// occupancy encoding used by the arbiter output stage.
package arb_pkg;

    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // First asserted valid starting at ptr and wrapping modulo n (n <= RR_MAX_N).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] valid,
                                         input int                  ptr,
                                         input int                  n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (!res.found && valid[j[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/round_robin_shared_adder_arbiter_dbuf.sv
// Two-entry FIFO-ordered output buffer; in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
module double_buffer_from_dally_harting
    import arb_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);

    buf_state_t       state_q, state_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] skid_q, skid_d;
    logic             push, pop;

    always_comb begin
        in_ready  = (state_q != BUF_FULL);
        out_valid = (state_q != BUF_EMPTY);
        out_data  = head_q;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = in_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b11: head_d = in_data;
                    2'b10: begin
                        skid_d  = in_data;
                        state_d = BUF_FULL;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    default: ;
                endcase
            end
            default: begin
                // Full: the older entry sits in head, the newer one in skid.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/round_robin_shared_adder_arbiter.sv
// Round-robin arbiter sharing one adder among n_req operand ports; tagged sums
// leave through a two-entry double buffer.
module round_robin_shared_adder_arbiter
    import arb_pkg::*;
#(
    parameter  int width = 8,
    parameter  int n_req = 4,
    localparam int id_w  = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [n_req-1:0]       req_valid,
    output logic [n_req-1:0]       req_ready,
    input  logic [n_req*width-1:0] req_a,
    input  logic [n_req*width-1:0] req_b,
    output logic                   sum_valid,
    input  logic                   sum_ready,
    output logic [width-1:0]       sum_data,
    output logic [id_w-1:0]        sum_id
);

    logic [id_w-1:0]       ptr_q, ptr_d;
    logic [id_w-1:0]       grant_idx;
    rr_pick_t              pick;
    logic                  up_ready;
    logic                  accept;
    logic [width-1:0]      a_sel, b_sel, sum_w;
    logic [width+id_w-1:0] buf_in, buf_out;

    always_comb begin
        pick      = rr_pick(RR_MAX_N'(req_valid), int'(ptr_q), n_req);
        grant_idx = id_w'(pick.idx);
        // Acceptance is held off during reset so nothing is consumed then.
        accept    = pick.found & up_ready & ~rst;
        req_ready = '0;
        req_ready[grant_idx] = accept;
        a_sel     = req_a[int'(grant_idx)*width +: width];
        b_sel     = req_b[int'(grant_idx)*width +: width];
        sum_w     = a_sel + b_sel;
        buf_in    = {sum_w, grant_idx};
        ptr_d     = ptr_q;
        if (accept) begin
            ptr_d = (int'(grant_idx) == n_req - 1) ? '0 : grant_idx + id_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    double_buffer_from_dally_harting #(
        .width(width + id_w)
    ) u_dbuf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_ready (up_ready),
        .in_data  (buf_in),
        .out_valid(sum_valid),
        .out_ready(sum_ready),
        .out_data (buf_out)
    );

    assign {sum_data, sum_id} = buf_out;

endmodule

// File: tb/tb_round_robin_shared_adder_arbiter.sv
// Bench for the shared-adder round-robin arbiter: directed vector table,
// stall/reset sequences and random traffic against a queue-based model.
module tb_round_robin_shared_adder_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic         sum_valid;
    logic         sum_ready;
    logic [W-1:0] sum_data;
    logic [1:0]   sum_id;

    always #5 clk = ~clk;

    round_robin_shared_adder_arbiter #(
        .width(W),
        .n_req(N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_data (sum_data),
        .sum_id   (sum_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] sum;
        int         id;
    } ent_t;

    ent_t       m_q[$];
    int         m_ptr = 0;
    int         m_g = 0;
    logic [3:0] m_exp_rdy = '0;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        srdy;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  e_rdy;
        logic        e_sv;
        logic        chk_d;
        logic [7:0]  e_sd;
        logic [1:0]  e_id;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: ports searched in order from the pointer; buffer is a 2-deep queue.
    task automatic model_check();
        bit found;
        int g;
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && req_valid[j]) begin
                found = 1;
                g = j;
            end
        end
        m_g = g;
        m_exp_rdy = (!rst && found && m_q.size() < 2) ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(m_exp_rdy));
        chk("sum_valid", 32'(sum_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("sum_data", 32'(sum_data), 32'(m_q[0].sum));
            chk("sum_id", 32'(sum_id), m_q[0].id);
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            m_q.delete();
            m_ptr = 0;
        end else begin
            if (m_q.size() != 0 && sum_ready) void'(m_q.pop_front());
            if (m_exp_rdy != 0) begin
                ent_t e;
                int av, bv;
                av = int'((req_a >> (8 * m_g)) & 32'hFF);
                bv = int'((req_b >> (8 * m_g)) & 32'hFF);
                e.sum = 8'((av + bv) % 256);
                e.id  = m_g;
                m_q.push_back(e);
                m_ptr = (m_g + 1) % N;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    localparam logic [31:0] A0 = 32'h03020100, B0 = 32'h0A0A0A0A;
    localparam logic [31:0] A1 = 32'h03C80100, B1 = 32'h0A640A0A;
    localparam logic [31:0] A2 = 32'h00050001, B2 = 32'h00060002;

    initial begin
        int         accepts;
        logic [7:0] hold_d;
        logic [1:0] hold_id;

        tbl[0]  = '{1'b1, 4'hF, 1'b1, A0, B0, 4'h0, 1'b0, 1'b1, 8'd0,  2'd0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, A0, B0, 4'h0, 1'b0, 1'b1, 8'd0,  2'd0};
        tbl[2]  = '{1'b1, 4'hF, 1'b1, A0, B0, 4'h0, 1'b0, 1'b1, 8'd0,  2'd0};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h1, 1'b0, 1'b1, 8'd0,  2'd0};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h2, 1'b1, 1'b1, 8'd10, 2'd0};
        tbl[5]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h4, 1'b1, 1'b1, 8'd11, 2'd1};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h8, 1'b1, 1'b1, 8'd12, 2'd2};
        tbl[7]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h1, 1'b1, 1'b1, 8'd13, 2'd3};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, A0, B0, 4'h2, 1'b1, 1'b1, 8'd10, 2'd0};
        tbl[9]  = '{1'b0, 4'h4, 1'b1, A1, B1, 4'h4, 1'b1, 1'b1, 8'd11, 2'd1};
        tbl[10] = '{1'b0, 4'h0, 1'b1, A1, B1, 4'h0, 1'b1, 1'b1, 8'd44, 2'd2};
        tbl[11] = '{1'b0, 4'h5, 1'b1, A2, B2, 4'h1, 1'b0, 1'b0, 8'd0,  2'd0};
        tbl[12] = '{1'b0, 4'h5, 1'b1, A2, B2, 4'h4, 1'b1, 1'b1, 8'd3,  2'd0};
        tbl[13] = '{1'b0, 4'h0, 1'b1, A2, B2, 4'h0, 1'b1, 1'b1, 8'd11, 2'd2};

        rst = 1'b1;
        req_valid = 4'hF;
        sum_ready = 1'b1;
        req_a = A0;
        req_b = B0;
        @(posedge clk);
        model_advance();
        #1;

        // Directed table: reset hold, rotation, single requester, wrap-around.
        for (int i = 0; i < 14; i++) begin
            rst       = tbl[i].rst;
            req_valid = tbl[i].vld;
            sum_ready = tbl[i].srdy;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            @(negedge clk);
            model_check();
            chk($sformatf("tbl%0d ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d sum_valid", i), 32'(sum_valid), 32'(tbl[i].e_sv));
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d sum_data", i), 32'(sum_data), 32'(tbl[i].e_sd));
                chk($sformatf("tbl%0d sum_id", i), 32'(sum_id), 32'(tbl[i].e_id));
            end
            @(posedge clk);
            model_advance();
            #1;
        end

        // Output stall: exactly two accepts, then held outputs, then resume.
        rst = 1'b0;
        req_valid = 4'hF;
        sum_ready = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        accepts = 0;
        hold_d = '0;
        hold_id = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            model_check();
            if (req_ready != 0) accepts++;
            if (c == 2) begin
                hold_d = sum_data;
                hold_id = sum_id;
            end
            if (c > 2) begin
                chk("stall sum_data", 32'(sum_data), 32'(hold_d));
                chk("stall sum_id", 32'(sum_id), 32'(hold_id));
                chk("stall sum_valid", 32'(sum_valid), 32'd1);
            end
            @(posedge clk);
            model_advance();
            #1;
        end
        chk("stall accepts", accepts, 32'd2);
        sum_ready = 1'b1;
        repeat (6) cycle();

        // Reset with a full buffer drops both entries and rewinds the pointer.
        sum_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        model_check();
        chk("post-rst sum_valid", 32'(sum_valid), 32'd0);
        @(posedge clk);
        model_advance();
        #1;
        req_valid = 4'hF;
        sum_ready = 1'b1;
        @(negedge clk);
        model_check();
        chk("post-rst grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        model_advance();
        #1;
        repeat (3) cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            sum_ready = ($urandom_range(0, 3) != 0);
            req_a     = $urandom;
            req_b     = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
